// File: rtl/project_pkg.sv
// Shared constants and types for the serial front end: ASCII codes and the
// token-parser state encoding.
package project_pkg;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_0     = 8'h30;

  typedef enum logic [1:0] {P_IDLE, P_SIGN, P_DIGIT, P_SKIP} parser_state_t;

endpackage

// File: rtl/ascii_int_parser.sv
// Streaming ASCII-decimal tokenizer: turns a byte stream of signed integers
// separated by whitespace/commas into one-cycle value or error pulses.
module ascii_int_parser
  import project_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              flush,
  output logic [DATA_W-1:0] num_value,
  output logic              num_valid,
  output logic              num_err,
  output logic              busy
);

  localparam int ACC_W = DATA_W + 4;
  localparam int CNT_W = (MAX_DIGITS < 2) ? 1 : $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
  localparam logic [ACC_W-1:0] POS_LIM = ACC_W'((64'd1 << (DATA_W - 1)) - 64'd1);
  localparam logic [ACC_W-1:0] NEG_LIM = ACC_W'(64'd1 << (DATA_W - 1));

  parser_state_t     state_q, state_d;
  logic              neg_q, neg_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] num_value_q, num_value_d;
  logic              num_valid_q, num_valid_d;
  logic              num_err_q, num_err_d;
  logic              busy_q, busy_d;

  logic             is_digit, is_minus, is_plus, is_term;
  logic [ACC_W-1:0] digit_ext, acc_mac, acc_neg, limit;

  always_comb begin
    is_digit  = (rx_data >= ASCII_0) && (rx_data <= (ASCII_0 + 8'd9));
    is_minus  = (rx_data == ASCII_MINUS);
    is_plus   = (rx_data == ASCII_PLUS);
    is_term   = (rx_data == ASCII_SPACE) || (rx_data == ASCII_CR) ||
                (rx_data == ASCII_LF)    || (rx_data == ASCII_COMMA);
    digit_ext = ACC_W'(rx_data[3:0]);
  end

  // acc is 4 bits wider than the output, so acc*10+9 cannot wrap before the limit compare.
  always_comb begin
    acc_mac = (acc_q << 3) + (acc_q << 1) + digit_ext;
    acc_neg = -acc_q;
    limit   = neg_q ? NEG_LIM : POS_LIM;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    num_value_d = num_value_q;
    num_valid_d = 1'b0;
    num_err_d   = 1'b0;

    if (flush) begin
      state_d = P_IDLE;
    end else if (rx_valid) begin
      unique case (state_q)
        P_IDLE: begin
          if (is_minus) begin
            neg_d   = 1'b1;
            state_d = P_SIGN;
          end else if (is_plus) begin
            neg_d   = 1'b0;
            state_d = P_SIGN;
          end else if (is_digit) begin
            acc_d   = digit_ext;
            cnt_d   = CNT_W'(1);
            state_d = P_DIGIT;
          end else if (!is_term) begin
            state_d = P_SKIP;
          end
        end
        P_SIGN: begin
          if (is_digit) begin
            acc_d   = digit_ext;
            cnt_d   = CNT_W'(1);
            state_d = P_DIGIT;
          end else if (is_term) begin
            num_err_d = 1'b1;
            state_d   = P_IDLE;
          end else begin
            state_d = P_SKIP;
          end
        end
        P_DIGIT: begin
          if (is_digit) begin
            if ((cnt_q == CNT_MAX) || (acc_mac > limit)) begin
              state_d = P_SKIP;
            end else begin
              acc_d = acc_mac;
              cnt_d = cnt_q + 1'b1;
            end
          end else if (is_term) begin
            num_valid_d = 1'b1;
            num_value_d = neg_q ? acc_neg[DATA_W-1:0] : acc_q[DATA_W-1:0];
            state_d     = P_IDLE;
          end else begin
            state_d = P_SKIP;
          end
        end
        P_SKIP: begin
          if (is_term) begin
            num_err_d = 1'b1;
            state_d   = P_IDLE;
          end
        end
        default: state_d = P_IDLE;
      endcase
    end

    if (state_d == P_IDLE) begin
      neg_d = 1'b0;
      acc_d = '0;
      cnt_d = '0;
    end
    busy_d = (state_d != P_IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= P_IDLE;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      num_value_q <= '0;
      num_valid_q <= 1'b0;
      num_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      neg_q       <= neg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      num_value_q <= num_value_d;
      num_valid_q <= num_valid_d;
      num_err_q   <= num_err_d;
      busy_q      <= busy_d;
    end
  end

  assign num_value = num_value_q;
  assign num_valid = num_valid_q;
  assign num_err   = num_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ascii_int_parser.sv
// Directed bench for ascii_int_parser at DATA_W=8, MAX_DIGITS=3; expected
// values are hand-computed from the token rules.
module tb_ascii_int_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       flush;
  logic [7:0] num_value;
  logic       num_valid;
  logic       num_err;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;

  ascii_int_parser #(.DATA_W(8), .MAX_DIGITS(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .flush    (flush),
    .num_value(num_value),
    .num_valid(num_valid),
    .num_err  (num_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Pulses are high for one full cycle, so the falling edge sees each exactly once.
  always @(negedge clk) begin
    if (num_valid) valid_cnt++;
    if (num_err) err_cnt++;
    if (num_valid && num_err) both_cnt++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int v0, e0;
  int obs_v[4];
  int obs_val[4];

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; flush = 1'b0;
    idle(2);
    rst = 1'b0;
    check("reset_value", int'(num_value), 0);
    check("reset_valid", int'(num_valid), 0);
    check("reset_err",   int'(num_err),   0);
    check("reset_busy",  int'(busy),      0);

    // "12 " -> 12 on the edge after the space; busy falls on that edge.
    send_byte("1");
    check("t1_busy_rise", int'(busy), 1);
    send_byte("2");
    send_byte(" ");
    check("t1_valid", int'(num_valid), 1);
    check("t1_value", int'(num_value), 12);
    check("t1_err",   int'(num_err),   0);
    check("t1_busy_fall", int'(busy),  0);
    idle(1);
    check("t1_pulse_one_cycle", int'(num_valid), 0);

    // Negative boundary accepted, positive 128 rejected with value held.
    send_str("-128\r");
    check("t2_neg_valid", int'(num_valid), 1);
    check("t2_neg_value", int'(num_value), 8'h80);
    idle(1);
    v0 = valid_cnt;
    send_str("128 ");
    check("t2_pos_err",   int'(num_err),   1);
    check("t2_pos_valid", int'(num_valid), 0);
    check("t2_pos_held",  int'(num_value), 8'h80);
    idle(1);
    check("t2_no_valid",  valid_cnt - v0, 0);

    // Invalid char inside a token gives exactly one error, then recovery.
    v0 = valid_cnt; e0 = err_cnt;
    send_str("3a4 ");
    check("t3_err", int'(num_err), 1);
    send_str("7\n");
    check("t3_value", int'(num_value), 7);
    check("t3_valid", int'(num_valid), 1);
    idle(1);
    check("t3_err_count",   err_cnt - e0,   1);
    check("t3_valid_count", valid_cnt - v0, 1);
    send_str("1000 ");
    check("t3_digit_limit_err", int'(num_err), 1);
    check("t3_digit_limit_val", int'(num_value), 7);
    idle(1);

    // "5,6\n" with rx_valid held high for four consecutive cycles.
    v0 = valid_cnt;
    begin
      logic [7:0] seq [4];
      seq[0] = "5"; seq[1] = ","; seq[2] = "6"; seq[3] = 8'h0A;
      for (int i = 0; i < 4; i++) begin
        rx_data  = seq[i];
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        obs_v[i]   = int'(num_valid);
        obs_val[i] = int'(num_value);
      end
      rx_valid = 1'b0;
    end
    check("t4_first_valid",  obs_v[1],   1);
    check("t4_first_value",  obs_val[1], 5);
    check("t4_second_valid", obs_v[3],   1);
    check("t4_second_value", obs_val[3], 6);
    idle(1);
    check("t4_valid_count", valid_cnt - v0, 2);

    // Lone sign is an error; separator runs are silent; explicit plus.
    send_str("- ");
    check("t5_sign_err", int'(num_err), 1);
    idle(1);
    v0 = valid_cnt; e0 = err_cnt;
    begin
      logic [7:0] seps [4];
      seps[0] = " "; seps[1] = " "; seps[2] = 8'h0D; seps[3] = 8'h0A;
      for (int i = 0; i < 4; i++) begin
        send_byte(seps[i]);
        check($sformatf("t5_sep_busy%0d", i), int'(busy), 0);
      end
    end
    idle(1);
    check("t5_sep_pulses", (valid_cnt - v0) + (err_cnt - e0), 0);
    send_str("+9 ");
    check("t5_plus_value", int'(num_value), 9);
    check("t5_plus_valid", int'(num_valid), 1);
    idle(1);

    // flush coincident with a byte drops the partial token and the byte.
    send_str("45");
    v0 = valid_cnt; e0 = err_cnt;
    rx_data = "1"; rx_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; flush = 1'b0;
    check("t6_flush_busy", int'(busy), 0);
    send_str("9 ");
    check("t6_flush_value", int'(num_value), 9);
    idle(1);
    check("t6_flush_valid_count", valid_cnt - v0, 1);
    check("t6_flush_err_count",   err_cnt - e0,   0);

    // Same with rst, which additionally clears num_value.
    send_str("45");
    v0 = valid_cnt; e0 = err_cnt;
    rx_data = "1"; rx_valid = 1'b1; rst = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rst = 1'b0;
    check("t6_rst_busy",  int'(busy),      0);
    check("t6_rst_value", int'(num_value), 0);
    send_str("9 ");
    check("t6_rst_value9", int'(num_value), 9);
    idle(1);
    check("t6_rst_valid_count", valid_cnt - v0, 1);
    check("t6_rst_err_count",   err_cnt - e0,   0);

    check("never_both_pulses", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
